vga_text_timing: RTL and testbench

- Parametrised next-generation VGA timing and text-mode address generator for the character-editing display path.
- Generates programmable H/V timing with selectable sync polarity.
- Provides pixel coordinates, character-cell RAM address and glyph offsets directly, so the text RAM is addressed without external arithmetic.
- Delays sync/valid by a programmable pipeline depth so they align with pixel data returned by the RAM/font-ROM path.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_delay_line.sv | 36 +++
 rtl/vga_text_timing.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_text_timing.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, total-length helper and colour-bar table for the VGA text path.
// The VGA_TEST_PATTERN_EN build uses the colour-bar table.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned NUM_BARS = 8;

    // Index 0 is the leftmost bar.
    localparam logic [23:0] BAR_COLOURS [NUM_BARS] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width/depth-parametrised shift register with synchronous active-low clear to zero.
// DEPTH of 0 gives a plain wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (!clear_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_text_timing.sv
// VGA timing generator with incremental text-cell addressing and a delayed sync/valid path.
// Define VGA_TEST_PATTERN_EN to add the test_en input and the 8-bar colour pattern.
module vga_text_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned CELL_W    = 8,
    parameter int unsigned CELL_H    = 16,
    parameter int unsigned TEXT_COLS = 80,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned PIPE_DLY  = 2
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic [23:0]       pixel_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_en,
`endif
    output logic [9:0]        h_addr,
    output logic [9:0]        v_addr,
    output logic [ADDR_W-1:0] char_addr,
    output logic [3:0]        glyph_x,
    output logic [3:0]        glyph_y,
    output logic              addr_valid,
    output logic              frame_start,
    output logic              line_start,
    output logic              hsync,
    output logic              vsync,
    output logic              valid,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);

    localparam logic [XW-1:0]     X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0]     X_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0]     HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0]     HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0]     Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0]     Y_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0]     VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]        GX_LAST  = 4'(CELL_W - 1);
    localparam logic [3:0]        GY_LAST  = 4'(CELL_H - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(TEXT_COLS);

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned   DW       = 6;
    localparam logic [XW-1:0] BAR_LAST = XW'(H_ACTIVE / NUM_BARS - 1);
    logic [XW-1:0] bar_px_q;
    logic [2:0]    bar_q;
    logic [2:0]    bar_0;
`else
    localparam int unsigned DW = 3;
`endif

    logic              run_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [3:0]        gx_q;
    logic [3:0]        gy_q;
    logic [ADDR_W-1:0] col_q;
    logic [ADDR_W-1:0] row_q;
    logic              x_wrap, y_wrap, h_act, v_act, act;
    logic              hs_0, vs_0;
    logic [DW-1:0]     pipe_in, pipe_out;
    logic [23:0]       pix_q;
    logic [23:0]       rgb;

    assign x_wrap = (x_q == X_LAST);
    assign y_wrap = (y_q == Y_LAST);
    assign h_act  = (x_q < X_ACT);
    assign v_act  = (y_q < Y_ACT);
    assign act    = h_act && v_act;

    // run_q holds the counters at 0,0 for one cycle after release.
    always_ff @(posedge pclk) begin
        if (!reset) begin
            run_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            gx_q  <= '0;
            gy_q  <= '0;
            col_q <= '0;
            row_q <= '0;
`ifdef VGA_TEST_PATTERN_EN
            bar_px_q <= '0;
            bar_q    <= '0;
`endif
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                if (x_wrap) begin
                    x_q   <= '0;
                    gx_q  <= '0;
                    col_q <= '0;
`ifdef VGA_TEST_PATTERN_EN
                    bar_px_q <= '0;
                    bar_q    <= '0;
`endif
                    if (y_wrap) begin
                        y_q   <= '0;
                        gy_q  <= '0;
                        row_q <= '0;
                    end else begin
                        y_q <= y_q + 1'b1;
                        if (gy_q == GY_LAST) begin
                            gy_q  <= '0;
                            row_q <= row_q + ROW_STEP;
                        end else begin
                            gy_q <= gy_q + 1'b1;
                        end
                    end
                end else begin
                    x_q <= x_q + 1'b1;
                    if (gx_q == GX_LAST) begin
                        gx_q  <= '0;
                        col_q <= col_q + 1'b1;
                    end else begin
                        gx_q <= gx_q + 1'b1;
                    end
`ifdef VGA_TEST_PATTERN_EN
                    if (bar_px_q == BAR_LAST) begin
                        bar_px_q <= '0;
                        bar_q    <= bar_q + 1'b1;
                    end else begin
                        bar_px_q <= bar_px_q + 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!reset || !run_q) begin
            addr_valid  <= 1'b0;
            h_addr      <= '0;
            v_addr      <= '0;
            glyph_x     <= '0;
            glyph_y     <= '0;
            char_addr   <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            hs_0        <= 1'b0;
            vs_0        <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            bar_0       <= '0;
`endif
        end else begin
            addr_valid  <= act;
            h_addr      <= act ? 10'(x_q) : '0;
            v_addr      <= act ? 10'(y_q) : '0;
            glyph_x     <= act ? gx_q : '0;
            glyph_y     <= act ? gy_q : '0;
            char_addr   <= act ? row_q + col_q : '0;
            frame_start <= (x_q == '0) && (y_q == '0);
            line_start  <= (x_q == '0) && v_act;
            hs_0        <= (x_q >= HS_START) && (x_q < HS_END);
            vs_0        <= (y_q >= VS_START) && (y_q < VS_END);
`ifdef VGA_TEST_PATTERN_EN
            bar_0       <= act ? bar_q : '0;
`endif
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    assign pipe_in = {hs_0, vs_0, addr_valid, bar_0};
`else
    assign pipe_in = {hs_0, vs_0, addr_valid};
`endif

    vga_delay_line #(
        .WIDTH(DW),
        .DEPTH(PIPE_DLY)
    ) u_sync_dly (
        .clk    (pclk),
        .clear_n(reset),
        .din    (pipe_in),
        .dout   (pipe_out)
    );

    assign hsync = pipe_out[DW-1] ? HS_POL : ~HS_POL;
    assign vsync = pipe_out[DW-2] ? VS_POL : ~VS_POL;
    assign valid = pipe_out[DW-3];

    // pixel_in is captured on the PIPE_DLY-th edge after address launch, landing with valid.
    always_ff @(posedge pclk) begin
        if (!reset) begin
            pix_q <= '0;
        end else begin
            pix_q <= pixel_in;
        end
    end

    always_comb begin
        rgb = valid ? pix_q : 24'h0;
`ifdef VGA_TEST_PATTERN_EN
        if (test_en) begin
            rgb = valid ? BAR_COLOURS[pipe_out[2:0]] : 24'h0;
        end
`endif
    end

    assign vga_r = rgb[23:16];
    assign vga_g = rgb[15:8];
    assign vga_b = rgb[7:0];

endmodule

// File: tb/tb_vga_text_timing.sv
// Directed bench: a default 640x480 instance for line timing and a reduced-timing instance
// (80x55 totals, 8 text columns) for frame-level, addressing, RGB and reset scenarios.
module tb_vga_text_timing;

    logic        pclk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] pixel_in = 24'h0;
`ifdef VGA_TEST_PATTERN_EN
    logic        test_en = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;

    logic [9:0]  d_h_addr, d_v_addr, s_h_addr, s_v_addr;
    logic [11:0] d_char_addr, s_char_addr;
    logic [3:0]  d_glyph_x, d_glyph_y, s_glyph_x, s_glyph_y;
    logic        d_addr_valid, d_frame_start, d_line_start, d_hsync, d_vsync, d_valid;
    logic        s_addr_valid, s_frame_start, s_line_start, s_hsync, s_vsync, s_valid;
    logic [7:0]  d_vga_r, d_vga_g, d_vga_b, s_vga_r, s_vga_g, s_vga_b;

    always #5 pclk = ~pclk;

    vga_text_timing u_dut_def (
        .pclk       (pclk),
        .reset      (reset),
        .pixel_in   (pixel_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_en    (test_en),
`endif
        .h_addr     (d_h_addr),
        .v_addr     (d_v_addr),
        .char_addr  (d_char_addr),
        .glyph_x    (d_glyph_x),
        .glyph_y    (d_glyph_y),
        .addr_valid (d_addr_valid),
        .frame_start(d_frame_start),
        .line_start (d_line_start),
        .hsync      (d_hsync),
        .vsync      (d_vsync),
        .valid      (d_valid),
        .vga_r      (d_vga_r),
        .vga_g      (d_vga_g),
        .vga_b      (d_vga_b)
    );

    vga_text_timing #(
        .H_ACTIVE (64),
        .H_FP     (4),
        .H_SYNC   (8),
        .H_BP     (4),
        .V_ACTIVE (48),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .TEXT_COLS(8)
    ) u_dut_small (
        .pclk       (pclk),
        .reset      (reset),
        .pixel_in   (pixel_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_en    (test_en),
`endif
        .h_addr     (s_h_addr),
        .v_addr     (s_v_addr),
        .char_addr  (s_char_addr),
        .glyph_x    (s_glyph_x),
        .glyph_y    (s_glyph_y),
        .addr_valid (s_addr_valid),
        .frame_start(s_frame_start),
        .line_start (s_line_start),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .valid      (s_valid),
        .vga_r      (s_vga_r),
        .vga_g      (s_vga_g),
        .vga_b      (s_vga_b)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    // Align base to a small-instance frame_start; offset k then shows stage-0 pixel
    // (k mod 80, k div 80), with sync/valid/RGB two cycles later.
    task automatic sync_small();
        int n = 0;
        while (s_frame_start !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        total++;
        if (s_frame_start !== 1'b1) begin
            bad++;
            $display("FAIL sync_small: frame_start=%b after %0d cycles, required 1", s_frame_start, n);
        end
        base = cyc;
    endtask

    task automatic goto(input int off);
        while (cyc - base < off) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total++;
        if ({s_hsync, s_vsync, s_valid, s_addr_valid, s_frame_start, s_line_start} !== 6'b110000) begin
            bad++;
            $display("FAIL reset_flags small: got %b required 110000",
                     {s_hsync, s_vsync, s_valid, s_addr_valid, s_frame_start, s_line_start});
        end
        total++;
        if ({d_hsync, d_vsync, d_valid, d_addr_valid} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_flags default: got %b required 1100",
                     {d_hsync, d_vsync, d_valid, d_addr_valid});
        end
        total++;
        if ({s_h_addr, s_v_addr, s_char_addr, s_vga_r, s_vga_g, s_vga_b} !== 56'h0) begin
            bad++;
            $display("FAIL reset_addr_rgb: got %h required 0",
                     {s_h_addr, s_v_addr, s_char_addr, s_vga_r, s_vga_g, s_vga_b});
        end
        reset = 1'b1;
        tick();
        total++;
        if ({s_frame_start, d_frame_start} !== 2'b00) begin
            bad++;
            $display("FAIL release_cycle1 frame_start: got %b required 00", {s_frame_start, d_frame_start});
        end
        tick();
        total++;
        if ({s_frame_start, d_frame_start, s_line_start, d_line_start, s_addr_valid} !== 5'b11111) begin
            bad++;
            $display("FAIL release_cycle2 starts: got %b required 11111",
                     {s_frame_start, d_frame_start, s_line_start, d_line_start, s_addr_valid});
        end
    endtask

    // Entered on the default instance's first line_start.
    task automatic test_default_line();
        int first_low = -1;
        int low_cnt = 0;
        int v_cnt = 0;
        for (int n = 0; n < 800; n++) begin
            if (n > 0) tick();
            if (d_hsync === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = n;
            end
            if (d_valid === 1'b1) v_cnt++;
        end
        total++;
        if (first_low != 658) begin
            bad++;
            $display("FAIL hsync_start: got %0d required 658", first_low);
        end
        total++;
        if (low_cnt != 96) begin
            bad++;
            $display("FAIL hsync_width: got %0d required 96", low_cnt);
        end
        total++;
        if (v_cnt != 640) begin
            bad++;
            $display("FAIL valid_per_line: got %0d required 640", v_cnt);
        end
        tick();
        total++;
        if (d_line_start !== 1'b1) begin
            bad++;
            $display("FAIL next_line_start: got %b required 1", d_line_start);
        end
    endtask

    task automatic test_frame();
        int vcnt = 0;
        sync_small();
        for (int off = 0; off <= 4400; off++) begin
            goto(off);
            if (off < 4400 && s_valid === 1'b1) vcnt++;
            case (off)
                69, 78, 4001, 4162: begin
                    total++;
                    if ((off == 69 || off == 78) ? (s_hsync !== 1'b1) : (s_vsync !== 1'b1)) begin
                        bad++;
                        $display("FAIL sync_inactive @%0d: hs=%b vs=%b required 1", off, s_hsync, s_vsync);
                    end
                end
                70, 77, 4002, 4161: begin
                    total++;
                    if ((off == 70 || off == 77) ? (s_hsync !== 1'b0) : (s_vsync !== 1'b0)) begin
                        bad++;
                        $display("FAIL sync_active @%0d: hs=%b vs=%b required 0", off, s_hsync, s_vsync);
                    end
                end
                80, 3840: begin
                    total++;
                    if (s_line_start !== (off == 80)) begin
                        bad++;
                        $display("FAIL line_start @%0d: got %b required %b", off, s_line_start, off == 80);
                    end
                end
                4399, 4400: begin
                    total++;
                    if (s_frame_start !== (off == 4400)) begin
                        bad++;
                        $display("FAIL frame_period @%0d: got %b required %b", off, s_frame_start, off == 4400);
                    end
                end
                default: ;
            endcase
        end
        total++;
        if (vcnt != 3072) begin
            bad++;
            $display("FAIL valid_per_frame: got %0d required 3072", vcnt);
        end
    endtask

    task automatic test_char_addr();
        int offs[5]  = '{0, 64, 1288, 1630, 3823};
        int ex_h[5]  = '{0, 0, 8, 30, 63};
        int ex_v[5]  = '{0, 0, 16, 20, 47};
        int ex_ca[5] = '{0, 0, 9, 11, 23};
        int ex_gx[5] = '{0, 0, 0, 6, 7};
        int ex_gy[5] = '{0, 0, 0, 4, 15};
        int ex_av[5] = '{1, 0, 1, 1, 1};
        logic [40:0] got, exp;
        sync_small();
        for (int i = 0; i < 5; i++) begin
            goto(offs[i]);
            got = {s_h_addr, s_v_addr, s_char_addr, s_glyph_x, s_glyph_y, s_addr_valid};
            exp = {10'(ex_h[i]), 10'(ex_v[i]), 12'(ex_ca[i]), 4'(ex_gx[i]), 4'(ex_gy[i]),
                   1'(ex_av[i])};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL char_addr #%0d: h/v/ca/gx/gy/av got %0d/%0d/%0d/%0d/%0d/%b required %0d/%0d/%0d/%0d/%0d/%0d",
                         i, s_h_addr, s_v_addr, s_char_addr, s_glyph_x, s_glyph_y, s_addr_valid,
                         ex_h[i], ex_v[i], ex_ca[i], ex_gx[i], ex_gy[i], ex_av[i]);
            end
        end
    endtask

    task automatic test_rgb();
        int          offs[7] = '{1, 2, 65, 66, 100, 101, 4000};
        logic [24:0] exp[7]  = '{25'h0, {1'b1, 24'h123456}, {1'b1, 24'h123456}, 25'h0,
                                 {1'b1, 24'h123456}, {1'b1, 24'hABCDEF}, 25'h0};
        pixel_in = 24'h123456;
        sync_small();
        for (int i = 0; i < 7; i++) begin
            goto(offs[i]);
            total++;
            if ({s_valid, s_vga_r, s_vga_g, s_vga_b} !== exp[i]) begin
                bad++;
                $display("FAIL rgb @%0d: valid/rgb got %b/%h required %b/%h", offs[i], s_valid,
                         {s_vga_r, s_vga_g, s_vga_b}, exp[i][24], exp[i][23:0]);
            end
            if (offs[i] == 100) pixel_in = 24'hABCDEF;
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        int          offs[8] = '{2, 9, 10, 18, 26, 58, 65, 66};
        logic [24:0] exp[8]  = '{{1'b1, 24'hFFFFFF}, {1'b1, 24'hFFFFFF}, {1'b1, 24'hFFFF00},
                                 {1'b1, 24'h00FFFF}, {1'b1, 24'h00FF00}, {1'b1, 24'h000000},
                                 {1'b1, 24'h000000}, 25'h0};
        test_en = 1'b1;
        sync_small();
        for (int i = 0; i < 8; i++) begin
            goto(offs[i]);
            total++;
            if ({s_valid, s_vga_r, s_vga_g, s_vga_b} !== exp[i]) begin
                bad++;
                $display("FAIL bars @%0d: valid/rgb got %b/%h required %b/%h", offs[i], s_valid,
                         {s_vga_r, s_vga_g, s_vga_b}, exp[i][24], exp[i][23:0]);
            end
        end
        test_en = 1'b0;
    endtask
`endif

    task automatic test_mid_reset();
        sync_small();
        goto(1630);
        reset = 1'b0;
        tick();
        total++;
        if ({s_h_addr, s_v_addr, s_char_addr, s_glyph_x, s_glyph_y} !== 40'h0) begin
            bad++;
            $display("FAIL mid_reset_addr: got %h required 0",
                     {s_h_addr, s_v_addr, s_char_addr, s_glyph_x, s_glyph_y});
        end
        total++;
        if ({s_hsync, s_vsync, s_valid, s_addr_valid, s_frame_start, s_line_start,
             d_hsync, d_vsync, d_valid} !== 9'b110000110) begin
            bad++;
            $display("FAIL mid_reset_flags: got %b required 110000110",
                     {s_hsync, s_vsync, s_valid, s_addr_valid, s_frame_start, s_line_start,
                      d_hsync, d_vsync, d_valid});
        end
        total++;
        if ({s_vga_r, s_vga_g, s_vga_b} !== 24'h0) begin
            bad++;
            $display("FAIL mid_reset_rgb: got %h required 000000", {s_vga_r, s_vga_g, s_vga_b});
        end
        reset = 1'b1;
        tick();
        total++;
        if ({s_frame_start, s_addr_valid} !== 2'b00) begin
            bad++;
            $display("FAIL restart_cycle1: fs/av got %b required 00", {s_frame_start, s_addr_valid});
        end
        tick();
        total++;
        if ({s_frame_start, s_addr_valid, s_h_addr, s_v_addr} !== {2'b11, 20'h0}) begin
            bad++;
            $display("FAIL restart_cycle2: fs/av/h/v got %b/%b/%0d/%0d required 1/1/0/0",
                     s_frame_start, s_addr_valid, s_h_addr, s_v_addr);
        end
        tick();
        total++;
        if ({s_frame_start, s_h_addr, s_glyph_x} !== {1'b0, 10'd1, 4'd1}) begin
            bad++;
            $display("FAIL restart_cycle3: fs/h/gx got %b/%0d/%0d required 0/1/1",
                     s_frame_start, s_h_addr, s_glyph_x);
        end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_frame();
        test_char_addr();
        test_rgb();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
